// File: rtl/img_mem_ctrl.sv
// img_mem_ctrl: image data memory and access controller feeding the 8-bit
// memory bus. Reads complete RD_LAT clocks after acceptance, writes take 1.
// mem_bus is driven from posedge flops so the data register can capture it
// on the falling edge.
// Optional feature: define IMG_MEM_STATS_EN to add saturating rd_count and
// wr_count outputs.
//
// state | meaning
// IDLE  | waiting for a request; wr_req wins over rd_req
// RD    | read in flight, latency counter running down to zero
// WR    | write in flight, commits on the next posedge
module img_mem_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        mem_bus,
    output logic              mem_ready,
    output logic              busy,
    output logic              addr_err
`ifdef IMG_MEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        mem_bus_q, mem_bus_d;
    logic              mem_ready_q, mem_ready_d;
    logic              busy_q, busy_d;
    logic              addr_err_q, addr_err_d;
    logic              mem_we;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        rd_data;

    logic [7:0] mem [0:DEPTH-1];

    assign in_range = (32'(addr_q) < 32'(DEPTH));
    assign idx      = addr_q[IDX_W-1:0];
    assign rd_data  = mem[idx];

    // Control state; the memory array itself is deliberately not reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= 8'h00;
            cnt_q       <= 3'd0;
            mem_bus_q   <= 8'h00;
            mem_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            mem_bus_q   <= mem_bus_d;
            mem_ready_q <= mem_ready_d;
            busy_q      <= busy_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Write port; mem_we derives from state_q, so a reset during WR drops the write.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= data_q;
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        mem_bus_d   = mem_bus_q;
        mem_ready_d = 1'b0;
        addr_err_d  = addr_err_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    addr_d  = addr;
                    data_d  = wr_data;
                    state_d = WR;
                end else if (rd_req) begin
                    addr_d  = addr;
                    cnt_d   = 3'(RD_LAT - 1);
                    state_d = RD;
                end
            end
            RD: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    mem_bus_d   = in_range ? rd_data : 8'h00;
                    mem_ready_d = 1'b1;
                    state_d     = IDLE;
                    if (!in_range) addr_err_d = 1'b1;
                end
            end
            WR: begin
                mem_we      = in_range;
                mem_ready_d = 1'b1;
                state_d     = IDLE;
                if (!in_range) addr_err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign mem_bus   = mem_bus_q;
    assign mem_ready = mem_ready_q;
    assign busy      = busy_q;
    assign addr_err  = addr_err_q;

`ifdef IMG_MEM_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    // Completed-access counters, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= 16'h0000;
            wr_count_q <= 16'h0000;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Out-of-range writes still count as completed writes.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == RD && cnt_q == 3'd0 && rd_count_q != 16'hFFFF)
            rd_count_d = rd_count_q + 16'd1;
        if (state_q == WR && wr_count_q != 16'hFFFF)
            wr_count_d = wr_count_q + 16'd1;
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_img_mem_ctrl.sv
// Self-checking bench for img_mem_ctrl (DEPTH=256, RD_LAT=2). Expected read
// data is pushed to a queue when a read is issued and popped when mem_ready
// arrives.
module tb_img_mem_ctrl;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rd_req = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [7:0]        wr_data = 8'h00;
    logic [7:0]        mem_bus;
    logic              mem_ready;
    logic              busy;
    logic              addr_err;
`ifdef IMG_MEM_STATS_EN
    logic [15:0]       rd_count;
    logic [15:0]       wr_count;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  model [0:DEPTH-1];
    logic [7:0]  sb [$];

    img_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .addr     (addr),
        .wr_data  (wr_data),
        .mem_bus  (mem_bus),
        .mem_ready(mem_ready),
        .busy     (busy),
        .addr_err (addr_err)
`ifdef IMG_MEM_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until mem_ready is seen, bounded.
    task automatic wait_ready(output int lat);
        lat = 0;
        while (!mem_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit also_rd);
        int lat;
        @(negedge clk);
        wr_req = 1'b1; rd_req = also_rd; addr = a; wr_data = d;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        chk("wr_busy", busy, 1);
        if (a < DEPTH) model[a] = d;
        wait_ready(lat);
        chk("wr_lat", lat, 1);
        @(negedge clk);
        chk("wr_pulse", mem_ready, 0);
    endtask

    task automatic do_read(input logic [15:0] a);
        int lat;
        logic [7:0] e;
        sb.push_back((a < DEPTH) ? model[a] : 8'h00);
        @(negedge clk);
        rd_req = 1'b1; addr = a;
        @(negedge clk);
        rd_req = 1'b0;
        chk("rd_busy", busy, 1);
        wait_ready(lat);
        chk("rd_lat", lat, RD_LAT);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd_data", mem_bus, e);
        end
        @(negedge clk);
        chk("rd_pulse", mem_ready, 0);
    endtask

    initial begin
        int   lat;
        bit   seen;
        logic [7:0] rnd [4];

        // Async reset asserted mid-cycle; outputs must clear immediately.
        #12 rst = 1'b1;
        #1;
        chk("rst_bus",   mem_bus,   8'h00);
        chk("rst_busy",  busy,      0);
        chk("rst_ready", mem_ready, 0);
        chk("rst_err",   addr_err,  0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Basic write then read.
        do_write(16'h0010, 8'hA5, 1'b0);
        do_read(16'h0010);
        repeat (3) @(negedge clk);
        chk("bus_hold", mem_bus, 8'hA5);

        // Simultaneous requests: write wins, read dropped, bus untouched.
        do_write(16'h0020, 8'h3C, 1'b1);
        chk("wr_no_bus", mem_bus, 8'hA5);
        do_read(16'h0020);

        // Write request during a busy read is ignored.
        sb.push_back(model[16'h0010]);
        @(negedge clk);
        rd_req = 1'b1; addr = 16'h0010;
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b1; wr_data = 8'hFF;
        wait_ready(lat);
        wr_req = 1'b0;
        chk("busy_rd_lat", lat, RD_LAT);
        chk("busy_rd_data", mem_bus, sb.pop_front());
        @(negedge clk);
        chk("busy_no_ready", mem_ready, 0);
        do_read(16'h0010);

        // Out-of-range accesses.
        do_write(16'h0000, 8'h5A, 1'b0);
        chk("err_clear", addr_err, 0);
        do_read(16'h0100);
        chk("err_set", addr_err, 1);
        do_write(16'h0100, 8'h77, 1'b0);
        do_read(16'h0000);
        chk("err_sticky", addr_err, 1);

        // Random data, writes then back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            rnd[i] = 8'($urandom_range(0, 255));
            do_write(16'(16'h0040 + i), rnd[i], 1'b0);
        end
        for (int i = 0; i < 4; i++) do_read(16'(16'h0040 + i));

        // Reset during a read: abandoned, no mem_ready, memory kept.
        @(negedge clk);
        rd_req = 1'b1; addr = 16'h0020;
        @(negedge clk);
        rd_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bus",   mem_bus,   8'h00);
        chk("mid_rst_ready", mem_ready, 0);
        chk("mid_rst_busy",  busy,      0);
        chk("mid_rst_err",   addr_err,  0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
        end
        rst = 1'b0;
        chk("mid_rst_noready", seen, 0);

        do_write(16'h0030, 8'h11, 1'b0);
        do_write(16'h0031, 8'h22, 1'b0);
        do_read(16'h0030);
        do_read(16'h0031);
        do_read(16'h0020);
`ifdef IMG_MEM_STATS_EN
        chk("rd_count", rd_count, 3);
        chk("wr_count", wr_count, 2);
`endif
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/img_mem_ctrl.md
Name: img_mem_ctrl

Overview:
- Image data memory plus access controller; the direct upstream source of the processor's 8-bit memory bus.
- The data register samples that bus on the falling clock edge.
- Serves read/write requests from the control unit with a fixed, parameterised read latency.
- Drives mem_bus from posedge-clocked flops so the value is stable at the data register's negedge capture.

Parameters:
ADDR_W, 16, address width in bits
DEPTH, 65536, number of 8-bit words implemented (addresses 0..DEPTH-1)
RD_LAT, 2, read latency in clocks from request acceptance to data on mem_bus (legal 1..7)

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
rd_req  input  1  read request, sampled only when idle
wr_req  input  1  write request, sampled only when idle
addr  input  ADDR_W  word address, latched at acceptance
wr_data  input  8  write data (data register output), latched at acceptance
mem_bus  output  8  read data to data register; holds last read value
mem_ready  output  1  one-cycle pulse on completion of any access
busy  output  1  high while an access is in progress
addr_err  output  1  sticky; set on any access with addr >= DEPTH

Behaviour:
- Reset (async, rst=1): state IDLE; mem_bus=8'h00; mem_ready=0; busy=0; addr_err=0; latency counter=0.
- Reset does not clear the memory array.
- Reset mid-access: the access is abandoned and no write is performed.
- FSM states: IDLE, RD, WR. busy = (state != IDLE), registered.
- IDLE with wr_req=1: latch addr and wr_data, go to WR. wr_req has priority.
- IDLE with both wr_req=1 and rd_req=1: the read is dropped, not queued; the requester re-asserts.
- IDLE with rd_req=1 only: latch addr, counter=RD_LAT-1, go to RD.
- RD state, each posedge:
  - counter != 0: decrement.
  - counter == 0: mem_bus <= mem[addr_q], mem_ready <= 1, go to IDLE.
- Read data therefore appears at posedge T+RD_LAT for a request accepted at posedge T.
- WR state, next posedge: mem[addr_q] <= data_q, mem_ready <= 1, go to IDLE. Write latency is 1. mem_bus is unchanged by writes.
- mem_ready is high for exactly one cycle per completed access; it is 0 in all other cycles.
- Requests while busy are ignored. The earliest next acceptance is the posedge after mem_ready rises.
- Back-to-back read: a request accepted at T is followed by a second accepted at T+RD_LAT+1.
- Out of range (addr_q >= DEPTH):
  - Read returns 8'h00.
  - Write is discarded.
  - Timing and mem_ready are identical to a legal access.
  - addr_err is set and stays set until reset.
- Read of a never-written address: value is undefined in simulation (X allowed). The bench writes before reading.
- Same-address write then read: the read returns the new value (the write completes before the read is accepted).

Optional Feature:
- Macro IMG_MEM_STATS_EN.
- When defined, two extra outputs are added:
  - rd_count [15:0]: increments on every completed read.
  - wr_count [15:0]: increments on every completed write, including discarded out-of-range accesses.
- Both counters saturate at 16'hFFFF and reset to 0 on rst.
- When undefined, neither the ports nor the logic exist, and the remaining behaviour is identical.

Test Plan:
- Reset then idle: assert rst for 3 cycles mid-clock -> immediately mem_bus=00, busy=0, mem_ready=0, addr_err=0.
- Write/read, RD_LAT=2:
  - Write 8'hA5 to addr 16'h0010 -> mem_ready pulses 1 cycle after acceptance.
  - Read 16'h0010 -> mem_bus=A5 with mem_ready exactly 2 posedges after acceptance.
  - mem_bus holds A5 afterwards.
- Simultaneous requests: in IDLE, rd_req=wr_req=1, addr=0x0020, wr_data=0x3C -> write performed, no read. A later read of 0x0020 returns 3C.
- Busy rejection: issue a read at 0x0010, pulse wr_req with data 0xFF to 0x0010 during busy -> ignored; a re-read returns A5.
- Out of range with DEPTH=256: read addr 0x0100 -> mem_bus=00, mem_ready at the normal latency, addr_err=1 and stays set. A write to 0x0100 does not alter addr 0x00.
- Reset mid-read, plus stats with IMG_MEM_STATS_EN:
  - Assert rst in the RD state -> no mem_ready, mem_bus=00. Memory contents survive.
  - With IMG_MEM_STATS_EN: after 3 reads and 2 writes, rd_count=3 and wr_count=2.
